dmem_responder: RTL

- Single-port data-memory responder (scratchpad slave) on the core's data-memory request/response interface.
- Accepts the load/store requests that the execute stage issues. Holds `mem_ready` low while the requester stalls, then returns one registered response per request.
- Adds programmable wait states and out-of-range error signalling.
- Sits between the core's dmem request port and on-chip SRAM.

---
 rtl/dmem_responder_pkg.sv | 46 ++++
 rtl/dmem_responder_sram_bank.sv | 46 ++++
 rtl/dmem_responder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
//   Shared definitions for the data-memory responder.
//   - DMEM_* parameter defaults (depth, base address, wait states)
//   - mem_in_type / mem_out_type : the core's dmem request/response bundles
//   - dmem_state_type            : responder FSM states
//   - addr_in_range()            : byte-address window check
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

  localparam int          DMEM_DEPTH_LOG2  = 12;
  localparam logic [31:0] DMEM_BASE_ADDR   = 32'h0000_0000;
  localparam int          DMEM_WAIT_STATES = 1;
  localparam int          DMEM_CNT_W       = 4;  // holds 0..15 wait states

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_error;
  } mem_out_type;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_type;

  // True when addr lies in [base, base + 4*2^depth_log2). The comparison is done
  // at 33 bits so a window ending exactly at 4 GiB does not wrap.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int          depth_log2);
    logic [32:0] limit;
    limit = {1'b0, base} + (33'd4 << depth_log2);
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/dmem_responder_sram_bank.sv
// -----------------------------------------------------------------------------
// sram_bank
//   Single-port 32-bit wide RAM with per-byte write enables and a registered
//   read port. Each byte lane is its own 8-bit array so the byte enables map
//   directly onto block-RAM write enables.
// Ports:
//   clk    : clock
//   re     : read enable; rdata updates on the next edge when high
//   we     : byte write enables (bit i writes wdata[8i+7:8i])
//   addr   : word address
//   wdata  : write data
//   rdata  : registered read data (holds when re is low)
// -----------------------------------------------------------------------------
module sram_bank #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  re,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
        if (we[gi]) begin
          lane_mem[addr] <= wdata[gi*8 +: 8];
        end
        if (re) begin
          rd_q <= lane_mem[addr];
        end
      end

      assign rdata[gi*8 +: 8] = rd_q;
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Scratchpad slave on the core's data-memory port. Accepts one request in
//   IDLE, waits WAIT_STATES cycles, then pulses mem_ready for one cycle with
//   read data or an out-of-range error. Writes commit in the response cycle.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   mem_valid  : request present (held stable until mem_ready)
//   mem_instr  : fetch tag, recorded only
//   mem_addr   : byte address (bits [1:0] ignored)
//   mem_wdata  : store data
//   mem_wstrb  : byte strobes, 0 = read
//   mem_ready  : one-cycle response pulse
//   mem_rdata  : read data, valid with mem_ready
//   mem_error  : access outside the memory window, valid with mem_ready
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2  = DMEM_DEPTH_LOG2,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int          WAIT_STATES = DMEM_WAIT_STATES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error
);

  localparam logic [DMEM_CNT_W-1:0] WAIT_LOAD = DMEM_CNT_W'(WAIT_STATES);

  dmem_state_type        state_q, state_d;
  logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
  mem_in_type            req_q, req_d;
  logic                  in_range_q, in_range_d;

  mem_in_type            req_in;
  mem_out_type           resp;

  logic [31:0]           offset_in;
  logic [31:0]           offset_q;
  logic                  sram_re;
  logic [3:0]            sram_we;
  logic [DEPTH_LOG2-1:0] sram_addr;
  logic [31:0]           sram_rdata;

  assign req_in = '{mem_valid: mem_valid,
                    mem_instr: mem_instr,
                    mem_addr:  mem_addr,
                    mem_wdata: mem_wdata,
                    mem_wstrb: mem_wstrb};

  assign offset_in = req_in.mem_addr - BASE_ADDR;
  assign offset_q  = req_q.mem_addr - BASE_ADDR;

  // ---------------------------------------------------------------------------
  // FSM: next state, counter and request capture
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    in_range_d = in_range_q;
    sram_re    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_in.mem_valid) begin
          req_d      = req_in;
          in_range_d = addr_in_range(req_in.mem_addr, BASE_ADDR, DEPTH_LOG2);
          cnt_d      = WAIT_LOAD;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
          end else begin
            // No wait states: the read must be launched from the live address
            // so data is ready in the very next (response) cycle.
            state_d = RESP;
            sram_re = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == DMEM_CNT_W'(1)) begin
          state_d = RESP;
          sram_re = 1'b1;
        end
      end
      RESP: begin
        // Always return to IDLE; a still-high mem_valid is not re-accepted here.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      in_range_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      in_range_q <= in_range_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory: the address comes straight from the port while IDLE (read at
  // acceptance) and from the captured request otherwise.
  // ---------------------------------------------------------------------------
  assign sram_addr = (state_q == IDLE) ? offset_in[DEPTH_LOG2+1:2]
                                       : offset_q[DEPTH_LOG2+1:2];
  assign sram_we   = (state_q == RESP && in_range_q) ? req_q.mem_wstrb : 4'b0000;

  sram_bank #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_sram (
    .clk   (clk),
    .re    (sram_re),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (req_q.mem_wdata),
    .rdata (sram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Response: decoded only from registers, so no input reaches the outputs
  // combinationally.
  // ---------------------------------------------------------------------------
  always_comb begin
    resp = '0;
    if (state_q == RESP) begin
      resp.mem_ready = 1'b1;
      resp.mem_error = ~in_range_q;
      if (in_range_q && req_q.mem_wstrb == 4'b0000) begin
        resp.mem_rdata = sram_rdata;
      end
    end
  end

  assign mem_ready = resp.mem_ready;
  assign mem_rdata = resp.mem_rdata;
  assign mem_error = resp.mem_error;

  // Bits captured for debug visibility or discarded by the word indexing.
  logic unused_bits;
  assign unused_bits = ^{offset_in[31:DEPTH_LOG2+2], offset_in[1:0],
                         offset_q[31:DEPTH_LOG2+2], offset_q[1:0],
                         req_q.mem_valid, req_q.mem_instr};

endmodule
